// File: rtl/mycpu_defs.sv
// Shared definitions for the core pipeline: bus widths, bus field offsets,
// load_op and csr_op bit positions.
// Imported by mem_stage and load_extend.
package mycpu_defs;

    // Bus widths
    localparam int ES_BUS_WIDTH  = 110;
    localparam int MS_BUS_WIDTH  = 104;
    localparam int FWD_BUS_WIDTH = 39;
    localparam int LOAD_OP_W     = 5;
    localparam int CSR_DATA_W    = 34;

    // es_to_ms_bus = {csr_data, mem_req, load_op, gr_we, dest, alu_result, pc}
    localparam int ES_PC_LSB     = 0;
    localparam int ES_ALU_LSB    = 32;
    localparam int ES_DEST_LSB   = 64;
    localparam int ES_GRWE_BIT   = 69;
    localparam int ES_LOP_LSB    = 70;
    localparam int ES_MEMREQ_BIT = 75;
    localparam int ES_CSR_LSB    = 76;

    // ms_to_ws_bus = {csr_data, gr_we, dest, final_result, pc}
    localparam int MS_PC_LSB     = 0;
    localparam int MS_RES_LSB    = 32;
    localparam int MS_DEST_LSB   = 64;
    localparam int MS_GRWE_BIT   = 69;
    localparam int MS_CSR_LSB    = 70;

    // load_op one-hot = {b, h, w, bu, hu}
    localparam int LOP_B  = 4;
    localparam int LOP_H  = 3;
    localparam int LOP_W  = 2;
    localparam int LOP_BU = 1;
    localparam int LOP_HU = 0;

    // csr_op bit order = {csrrd, csrwr, csrxchg, ertn, syscall}
    localparam int CSR_OP_CSRRD   = 4;
    localparam int CSR_OP_CSRWR   = 3;
    localparam int CSR_OP_CSRXCHG = 2;
    localparam int CSR_OP_ERTN    = 1;
    localparam int CSR_OP_SYSCALL = 0;

endpackage

// File: rtl/load_extend.sv
// Load data extraction: selects byte/halfword/word from the SRAM word by the
// low address bits and sign- or zero-extends it. Purely combinational.
// Ports: i_addr (addr[1:0]), i_load_op (one-hot {b,h,w,bu,hu}), i_rdata, o_result.
module load_extend
    import mycpu_defs::*;
(
    input  logic [1:0]           i_addr,
    input  logic [LOAD_OP_W-1:0] i_load_op,
    input  logic [31:0]          i_rdata,
    output logic [31:0]          o_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Halfword loads use only addr[1]; addr[0] is ignored.
    assign w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_result = i_rdata;
        if (i_load_op[LOP_B])
            o_result = {{24{w_byte[7]}}, w_byte};
        else if (i_load_op[LOP_BU])
            o_result = {24'd0, w_byte};
        else if (i_load_op[LOP_H])
            o_result = {{16{w_half[15]}}, w_half};
        else if (i_load_op[LOP_HU])
            o_result = {16'd0, w_half};
        else
            o_result = i_rdata;
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: holds one instruction from EXE, waits for its data-SRAM
// response, extracts load data and forwards the result to WB and ID.
// Ports: clk/resetn; EXE handshake (es_to_ms_valid, es_to_ms_bus, ms_allowin);
// WB handshake (ws_allowin, ms_to_ws_valid, ms_to_ws_bus); SRAM response
// (data_sram_data_ok, data_sram_rdata); wb_flush; ms_fwd_bus to ID.
module mem_stage
    import mycpu_defs::*;
#(
    parameter int ES_BUS_W = ES_BUS_WIDTH,
    parameter int MS_BUS_W = MS_BUS_WIDTH,
    parameter int DISC_W   = 2
)(
    input  logic                clk,
    input  logic                resetn,
    input  logic                es_to_ms_valid,
    input  logic [ES_BUS_W-1:0] es_to_ms_bus,
    output logic                ms_allowin,
    input  logic                ws_allowin,
    output logic                ms_to_ws_valid,
    output logic [MS_BUS_W-1:0] ms_to_ws_bus,
    input  logic                data_sram_data_ok,
    input  logic [31:0]         data_sram_rdata,
    input  logic                wb_flush,
    output logic [38:0]         ms_fwd_bus
);

    localparam logic [DISC_W-1:0] DISC_ONE = DISC_W'(1);
    localparam logic [DISC_W-1:0] DISC_MAX = {DISC_W{1'b1}};

    logic                  r_ms_valid;
    logic [ES_BUS_W-1:0]   r_bus;
    logic [DISC_W-1:0]     r_disc_cnt;
    logic                  r_rbuf_valid;
    logic [31:0]           r_rbuf;

    logic [31:0]           w_pc;
    logic [31:0]           w_alu_result;
    logic [4:0]            w_dest;
    logic                  w_gr_we;
    logic [LOAD_OP_W-1:0]  w_load_op;
    logic                  w_mem_req;
    logic [CSR_DATA_W-1:0] w_csr_data;

    logic                  w_disc_active;
    logic                  w_data_ok_eff;
    logic                  w_ready_go;
    logic                  w_leave;
    logic                  w_rbuf_set;
    logic                  w_disc_inc;
    logic                  w_disc_dec;
    logic [31:0]           w_load_data;
    logic [31:0]           w_load_res;
    logic [31:0]           w_final_result;

    assign w_pc         = r_bus[ES_PC_LSB   +: 32];
    assign w_alu_result = r_bus[ES_ALU_LSB  +: 32];
    assign w_dest       = r_bus[ES_DEST_LSB +: 5];
    assign w_gr_we      = r_bus[ES_GRWE_BIT];
    assign w_load_op    = r_bus[ES_LOP_LSB  +: LOAD_OP_W];
    assign w_mem_req    = r_bus[ES_MEMREQ_BIT];
    assign w_csr_data   = r_bus[ES_CSR_LSB  +: CSR_DATA_W];

    // A data_ok only belongs to the instruction in MEM once every response
    // owed to previously flushed requests has been swallowed.
    assign w_disc_active = (r_disc_cnt != '0);
    assign w_data_ok_eff = data_sram_data_ok & ~w_disc_active;

    assign w_ready_go     = ~w_mem_req | w_data_ok_eff | r_rbuf_valid;
    assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
    assign ms_to_ws_valid = r_ms_valid & w_ready_go;
    assign w_leave        = ms_to_ws_valid & ws_allowin;

    // Response arrived but WB is stalled: keep it, SRAM will not repeat it.
    assign w_rbuf_set = r_ms_valid & w_mem_req & w_data_ok_eff & ~r_rbuf_valid
                      & ~ws_allowin & ~wb_flush;

    // A flushed memory instruction whose response is still in flight leaves
    // behind one response that must be dropped when it arrives.
    assign w_disc_inc = wb_flush & r_ms_valid & w_mem_req & ~w_data_ok_eff & ~r_rbuf_valid;
    assign w_disc_dec = data_sram_data_ok & w_disc_active;

    assign w_load_data = r_rbuf_valid ? r_rbuf : data_sram_rdata;

    load_extend u_load_extend (
        .i_addr    (w_alu_result[1:0]),
        .i_load_op (w_load_op),
        .i_rdata   (w_load_data),
        .o_result  (w_load_res)
    );

    assign w_final_result = (|w_load_op) ? w_load_res : w_alu_result;

    assign ms_to_ws_bus = {w_csr_data, w_gr_we, w_dest, w_final_result, w_pc};

    assign ms_fwd_bus = {r_ms_valid & (|w_load_op) & ~w_ready_go,
                         r_ms_valid & w_gr_we,
                         w_dest,
                         w_final_result};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ms_valid <= 1'b0;
        end else if (wb_flush) begin
            r_ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bus <= '0;
        end else if (es_to_ms_valid & ms_allowin) begin
            r_bus <= es_to_ms_bus;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rbuf_valid <= 1'b0;
            r_rbuf       <= '0;
        end else begin
            if (wb_flush | w_leave) begin
                r_rbuf_valid <= 1'b0;
            end else if (w_rbuf_set) begin
                r_rbuf_valid <= 1'b1;
            end
            if (w_rbuf_set) begin
                r_rbuf <= data_sram_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_disc_cnt <= '0;
        end else begin
            case ({w_disc_inc, w_disc_dec})
                2'b10: if (r_disc_cnt != DISC_MAX) r_disc_cnt <= r_disc_cnt + DISC_ONE;
                2'b01: r_disc_cnt <= r_disc_cnt - DISC_ONE;
                default: r_disc_cnt <= r_disc_cnt;
            endcase
        end
    end

    // More outstanding stale responses than the counter can track means the
    // upstream request limit was violated.
    disc_cnt_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
        !(w_disc_inc && !w_disc_dec && (r_disc_cnt == DISC_MAX)));

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic          clk;
    logic          resetn;
    logic          es_to_ms_valid;
    logic [109:0]  es_to_ms_bus;
    logic          ms_allowin;
    logic          ws_allowin;
    logic          ms_to_ws_valid;
    logic [103:0]  ms_to_ws_bus;
    logic          data_sram_data_ok;
    logic [31:0]   data_sram_rdata;
    logic          wb_flush;
    logic [38:0]   ms_fwd_bus;

    int checks = 0;
    int errors = 0;
    logic [103:0] exp_q[$];
    logic [103:0] exp_head;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_flush          (wb_flush),
        .ms_fwd_bus        (ms_fwd_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // load_op one-hot {b, h, w, bu, hu}
    localparam logic [4:0] OP_NONE = 5'b00000;
    localparam logic [4:0] OP_B    = 5'b10000;
    localparam logic [4:0] OP_H    = 5'b01000;
    localparam logic [4:0] OP_W    = 5'b00100;
    localparam logic [4:0] OP_BU   = 5'b00010;

    function automatic logic [109:0] mk_es(logic [33:0] csr, logic mr, logic [4:0] lop,
                                           logic we, logic [4:0] d, logic [31:0] alu,
                                           logic [31:0] pc);
        return {csr, mr, lop, we, d, alu, pc};
    endfunction

    function automatic logic [103:0] mk_ws(logic [33:0] csr, logic we, logic [4:0] d,
                                           logic [31:0] res, logic [31:0] pc);
        return {csr, we, d, res, pc};
    endfunction

    task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to MEM; returns at posedge+1 after it is accepted.
    task automatic send(input logic [109:0] b, input logic [103:0] exp, input bit push);
        int n;
        n = 0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        if (push) exp_q.push_back(exp);
        #1;
        while (!ms_allowin && n < 50) begin
            cycle();
            #1;
            n++;
        end
        if (n >= 50) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: got allowin=0 expected allowin=1");
        end
        cycle();
        es_to_ms_valid = 1'b0;
    endtask

    // Load held in MEM for dly cycles, then one data_ok carries rd.
    task automatic run_load(input string nm, input logic [4:0] lop, input logic [1:0] a,
                            input logic [31:0] rd, input int dly, input logic [31:0] expres);
        logic [31:0] alu;
        logic [31:0] pc;
        alu = {30'h0400_0000, a};
        pc  = 32'h1c00_0100;
        send(mk_es(34'h0, 1'b1, lop, 1'b1, 5'd7, alu, pc),
             mk_ws(34'h0, 1'b1, 5'd7, expres, pc), 1'b1);
        for (int i = 0; i < dly; i++) begin
            #1;
            chk({nm, "_blk_wait"}, ms_fwd_bus[38], 1);
            chk({nm, "_valid_wait"}, ms_to_ws_valid, 0);
            cycle();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = rd;
        #1;
        chk({nm, "_valid"}, ms_to_ws_valid, 1);
        chk({nm, "_blk_done"}, ms_fwd_bus[38], 0);
        chk({nm, "_fwd_result"}, ms_fwd_bus[31:0], expres);
        cycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
    endtask

    // Scoreboard monitor: every transfer to WB must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && ms_to_ws_valid && ws_allowin) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL retire_unexpected: got %h expected none", ms_to_ws_bus);
            end else begin
                exp_head = exp_q.pop_front();
                if (ms_to_ws_bus !== exp_head) begin
                    errors++;
                    $display("FAIL retire_bus: got %h expected %h", ms_to_ws_bus, exp_head);
                end
            end
        end
    end

    initial begin
        resetn            = 1'b0;
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = '0;
        wb_flush          = 1'b0;

        #3;
        chk("reset_valid", ms_to_ws_valid, 0);
        chk("reset_fwd", ms_fwd_bus, 0);
        chk("reset_allowin", ms_allowin, 1);
        cycle();
        cycle();
        resetn = 1'b1;
        cycle();

        // ALU op: one cycle in MEM
        send(mk_es(34'h5, 1'b0, OP_NONE, 1'b1, 5'd3, 32'h1234, 32'h1c00_0000),
             mk_ws(34'h5, 1'b1, 5'd3, 32'h1234, 32'h1c00_0000), 1'b1);
        #1;
        chk("alu_valid", ms_to_ws_valid, 1);
        chk("alu_blk", ms_fwd_bus[38], 0);
        chk("alu_rf_we", ms_fwd_bus[37], 1);
        chk("alu_fwd_result", ms_fwd_bus[31:0], 32'h1234);
        cycle();
        chk("alu_gone", ms_to_ws_valid, 0);

        // Loads: byte 2 of 0x80FF0000 is 0xFF -> ld.b sign-extends to all ones
        run_load("ldb",  OP_B,  2'd2, 32'h80FF_0000, 3, 32'hFFFF_FFFF);
        run_load("ldbu", OP_BU, 2'd2, 32'h0080_0000, 1, 32'h0000_0080);
        run_load("ldh",  OP_H,  2'd2, 32'h8001_0000, 1, 32'hFFFF_8001);
        run_load("ldb1", OP_B,  2'd1, 32'h0000_7F00, 0, 32'h0000_007F);

        // Flush a pending load, then its stale response must be discarded
        send(mk_es(34'h0, 1'b1, OP_W, 1'b1, 5'd9, 32'h2000_0000, 32'h1c00_0200), '0, 1'b0);
        wb_flush = 1'b1;
        #1;
        chk("flush_valid", ms_to_ws_valid, 0);
        cycle();
        wb_flush = 1'b0;
        chk("flush_cleared", ms_to_ws_valid, 0);
        send(mk_es(34'h0, 1'b1, OP_W, 1'b1, 5'd10, 32'h2000_0004, 32'h1c00_0204),
             mk_ws(34'h0, 1'b1, 5'd10, 32'h0000_5555, 32'h1c00_0204), 1'b1);
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_AAAA;
        #1;
        chk("disc_valid", ms_to_ws_valid, 0);
        chk("disc_blk", ms_fwd_bus[38], 1);
        cycle();
        data_sram_rdata = 32'h0000_5555;
        #1;
        chk("disc_next_valid", ms_to_ws_valid, 1);
        chk("disc_next_result", ms_fwd_bus[31:0], 32'h0000_5555);
        cycle();
        data_sram_data_ok = 1'b0;

        // Response buffer while WB stalls
        send(mk_es(34'h3, 1'b1, OP_W, 1'b1, 5'd11, 32'h3000_0000, 32'h1c00_0300),
             mk_ws(34'h3, 1'b1, 5'd11, 32'hDEAD_BEEF, 32'h1c00_0300), 1'b1);
        ws_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        #1;
        chk("rbuf_valid0", ms_to_ws_valid, 1);
        chk("rbuf_allowin0", ms_allowin, 0);
        cycle();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rbuf_hold_valid", ms_to_ws_valid, 1);
            chk("rbuf_hold_result", ms_fwd_bus[31:0], 32'hDEAD_BEEF);
            cycle();
        end
        ws_allowin = 1'b1;
        #1;
        chk("rbuf_release_allowin", ms_allowin, 1);
        cycle();
        chk("rbuf_gone", ms_to_ws_valid, 0);

        // Async reset with one stale response outstanding
        send(mk_es(34'h0, 1'b1, OP_W, 1'b1, 5'd12, 32'h4000_0000, 32'h1c00_0400), '0, 1'b0);
        wb_flush = 1'b1;
        cycle();
        wb_flush = 1'b0;
        send(mk_es(34'h0, 1'b1, OP_W, 1'b1, 5'd13, 32'h4000_0004, 32'h1c00_0404), '0, 1'b0);
        #1;
        chk("pre_reset_blk", ms_fwd_bus[38], 1);
        resetn = 1'b0;
        #1;
        chk("async_reset_valid", ms_to_ws_valid, 0);
        chk("async_reset_fwd", ms_fwd_bus, 0);
        chk("async_reset_allowin", ms_allowin, 1);
        #1;
        resetn = 1'b1;
        cycle();
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_0BAD;
        #1;
        chk("orphan_ok_valid", ms_to_ws_valid, 0);
        cycle();
        data_sram_data_ok = 1'b0;
        run_load("post_reset", OP_W, 2'd0, 32'h1357_9BDF, 0, 32'h1357_9BDF);

        // Back-to-back stores, one data_ok per cycle
        for (int i = 0; i < 5; i++) begin
            logic [31:0] alu;
            logic [31:0] pc;
            alu = 32'h5000_0000 + 32'(i * 4);
            pc  = 32'h1c00_0500 + 32'(i * 4);
            es_to_ms_valid = (i < 4);
            if (i < 4) begin
                es_to_ms_bus = mk_es(34'h0, 1'b1, OP_NONE, 1'b0, 5'd0, alu, pc);
                exp_q.push_back(mk_ws(34'h0, 1'b0, 5'd0, alu, pc));
            end
            data_sram_data_ok = (i > 0);
            #1;
            chk("store_allowin", ms_allowin, 1);
            if (i > 0) chk("store_valid", ms_to_ws_valid, 1);
            cycle();
        end
        es_to_ms_valid    = 1'b0;
        data_sram_data_ok = 1'b0;
        cycle();
        chk("store_drained", ms_to_ws_valid, 0);

        cycle();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
